// File: rtl/nvdla_sdp_core_gather.sv
// Narrow-to-wide beat gatherer: packs RATIO IW-bit beats into one OW-bit word, low segment first.
// A last-flagged beat flushes a partial word; a separate output register decouples downstream stalls.
module nvdla_sdp_core_gather #(
    parameter int IW    = 128,
    parameter int OW    = 512,
    parameter int RATIO = OW / IW
) (
    input  logic             nvdla_core_clk,
    input  logic             nvdla_core_rstn,
    input  logic             inp_pvld,
    output logic             inp_prdy,
    input  logic [IW-1:0]    inp_data,
    input  logic             inp_last,
    output logic             out_pvld,
    input  logic             out_prdy,
    output logic [OW-1:0]    out_data,
    output logic [RATIO-1:0] out_mask,
    output logic             out_last
);

    localparam logic [3:0] LAST_CNT = 4'(RATIO - 1);

    logic [3:0]       cnt_q, cnt_d;
    logic [OW-1:0]    asm_q;
    logic             out_pvld_q, out_pvld_d;
    logic [OW-1:0]    out_data_q, out_data_d;
    logic [RATIO-1:0] out_mask_q, out_mask_d;
    logic             out_last_q, out_last_d;

    logic             complete_s;
    logic             inp_acc_s;
    logic             out_acc_s;
    logic [OW-1:0]    merged_s;
    logic [RATIO-1:0] mask_s;

    // Handshake qualifiers; only the completing beat needs a free output slot.
    always_comb begin
        complete_s = (cnt_q == LAST_CNT) | inp_last;
        inp_prdy   = ~(out_pvld_q & ~out_prdy & complete_s);
        inp_acc_s  = inp_pvld & inp_prdy;
        out_acc_s  = out_pvld_q & out_prdy;
    end

    // Word as it would leave this cycle: stored segments below cnt, live beat at cnt, zeros above.
    always_comb begin
        merged_s = '0;
        mask_s   = '0;
        for (int i = 0; i < RATIO; i++) begin
            if (4'(i) < cnt_q) begin
                merged_s[i*IW +: IW] = asm_q[i*IW +: IW];
                mask_s[i]            = 1'b1;
            end else if (4'(i) == cnt_q) begin
                merged_s[i*IW +: IW] = inp_data;
                mask_s[i]            = 1'b1;
            end else begin
                merged_s[i*IW +: IW] = '0;
                mask_s[i]            = 1'b0;
            end
        end
    end

    // Next-state for the segment counter and the output register.
    always_comb begin
        cnt_d      = cnt_q;
        out_pvld_d = out_pvld_q;
        out_data_d = out_data_q;
        out_mask_d = out_mask_q;
        out_last_d = out_last_q;
        if (inp_acc_s) begin
            if (complete_s) begin
                cnt_d = 4'd0;
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end else begin
            cnt_d = cnt_q;
        end
        if (inp_acc_s && complete_s) begin
            out_pvld_d = 1'b1;
            out_data_d = merged_s;
            out_mask_d = mask_s;
            out_last_d = inp_last;
        end else if (out_acc_s) begin
            out_pvld_d = 1'b0;
        end else begin
            out_pvld_d = out_pvld_q;
        end
    end

    // Control and output state; reset drops any partial or pending word.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            cnt_q      <= 4'd0;
            out_pvld_q <= 1'b0;
            out_data_q <= '0;
            out_mask_q <= '0;
            out_last_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            out_pvld_q <= out_pvld_d;
            out_data_q <= out_data_d;
            out_mask_q <= out_mask_d;
            out_last_q <= out_last_d;
        end
    end

    // Assembly payload, deliberately unreset: segments above cnt are never exposed.
    always_ff @(posedge nvdla_core_clk) begin
        for (int i = 0; i < RATIO; i++) begin
            if (inp_acc_s && (cnt_q == 4'(i))) begin
                asm_q[i*IW +: IW] <= inp_data;
            end
        end
    end

    assign out_pvld = out_pvld_q;
    assign out_data = out_data_q;
    assign out_mask = out_mask_q;
    assign out_last = out_last_q;

endmodule
